// File: rtl/data_mem_sp.sv
// data_mem_sp: data memory with one write and one registered read port, write-first
// forwarding, sticky error flag and a clear engine that fills the array after reset or on request.
module data_mem_sp #(
    parameter int               WIDTH   = 8,
    parameter int               ADDR_W  = 8,
    parameter int               DEPTH   = 2 ** ADDR_W,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              err
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_err;

    logic              w_idle;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_do;
    logic              w_rd_do;
    logic              w_fwd;
    logic              w_start_clr;
    logic              w_clr_done;
    logic              w_bad_access;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_wdata;

    assign w_idle        = (r_state == S_IDLE);
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign w_wr_do       = w_idle && wr_en && w_wr_in_range;
    assign w_rd_do       = w_idle && rd_en && w_rd_in_range;
    assign w_fwd         = w_wr_do && (wr_addr == rd_addr);
    assign w_start_clr   = w_idle && clr;
    assign w_clr_done    = (r_cnt == LAST_ADDR);
    assign w_bad_access  = (!w_idle && (wr_en || rd_en))
                        || (w_idle && ((wr_en && !w_wr_in_range) || (rd_en && !w_rd_in_range)));

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (clr) w_next_state = S_CLEAR;
            S_CLEAR: if (w_clr_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // A clr pulse during a running clear does not restart the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_start_clr) begin
            r_cnt <= '0;
        end else if (!w_idle) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = wr_addr;
        w_mem_wdata = wr_data;
        if (!w_idle) begin
            w_mem_we    = rst_n;
            w_mem_addr  = r_cnt;
            w_mem_wdata = CLR_VAL;
        end else if (w_wr_do) begin
            w_mem_we    = rst_n;
        end
    end

    // NOTE: the array itself has no reset; the clear engine defines its
    // contents before any access is accepted.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_idle && rd_en;
            if (w_idle && rd_en) begin
                if (!w_rd_do) begin
                    r_rd_data <= '0;
                end else if (w_fwd) begin
                    r_rd_data <= wr_data;
                end else begin
                    r_rd_data <= r_mem[rd_addr];
                end
            end
            if (w_bad_access) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy     = (r_state == S_CLEAR);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_data_mem_sp.sv
// Bench for data_mem_sp: two instances (DEPTH 256 and 200) share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_data_mem_sp;

    localparam int D0 = 256;
    localparam int D1 = 200;

    logic       clk = 1'b0;
    logic       rst_n, clr, wr_en, rd_en;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic       busy0, busy1, rd_valid0, rd_valid1, err0, err1;
    logic [7:0] rd_data0, rd_data1;

    always #5 clk = ~clk;

    data_mem_sp #(.WIDTH(8), .ADDR_W(8), .DEPTH(D0), .CLR_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .err(err0)
    );

    data_mem_sp #(.WIDTH(8), .ADDR_W(8), .DEPTH(D1), .CLR_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .err(err1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: a clear empties the whole array at once and then blocks the
    // ports for DEPTH cycles; the observable behaviour is identical.
    logic [7:0] m_mem [2][256];
    int         m_busy_left [2];
    logic [7:0] m_rd_data [2];
    logic       m_rd_valid [2];
    logic       m_err [2];
    bit         m_known = 1'b0;

    task automatic fill(input int k);
        for (int a = 0; a < 256; a++) m_mem[k][a] = 8'h00;
    endtask

    task automatic step(input int k, input int dep);
        bit wr_ok, rd_ok;
        if (!rst_n) begin
            fill(k);
            m_busy_left[k] = dep;
            m_rd_data[k]   = 8'h00;
            m_rd_valid[k]  = 1'b0;
            m_err[k]       = 1'b0;
            return;
        end
        m_rd_valid[k] = 1'b0;
        if (m_busy_left[k] > 0) begin
            if (wr_en || rd_en) m_err[k] = 1'b1;
            m_busy_left[k]--;
            return;
        end
        wr_ok = wr_en && (int'(wr_addr) < dep);
        rd_ok = rd_en && (int'(rd_addr) < dep);
        if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) m_err[k] = 1'b1;
        if (rd_en) begin
            m_rd_valid[k] = 1'b1;
            if (!rd_ok)                          m_rd_data[k] = 8'h00;
            else if (wr_ok && wr_addr == rd_addr) m_rd_data[k] = wr_data;
            else                                 m_rd_data[k] = m_mem[k][rd_addr];
        end
        if (wr_ok) m_mem[k][wr_addr] = wr_data;
        if (clr) begin
            fill(k);
            m_busy_left[k] = dep;
        end
    endtask

    always @(posedge clk) begin
        step(0, D0);
        step(1, D1);
        if (!rst_n) m_known = 1'b1;
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("busy0",     busy0,     m_busy_left[0] > 0);
            check("rd_valid0", rd_valid0, m_rd_valid[0]);
            check("rd_data0",  rd_data0,  m_rd_data[0]);
            check("err0",      err0,      m_err[0]);
            check("busy1",     busy1,     m_busy_left[1] > 0);
            check("rd_valid1", rd_valid1, m_rd_valid[1]);
            check("rd_data1",  rd_data1,  m_rd_data[1]);
            check("err1",      err1,      m_err[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_clear(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 1000 && (busy0 || busy1); c++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            tick();
        end
    endtask

    initial begin
        int n0, n1, nb;
        rst_n = 1'b0;
        idle();
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_rd_data0", rd_data0, 0);
        check("reset_err0", err0, 0);
        check("reset_busy0", busy0, 1);
        wait_clear(n0, n1);
        check("busy_len_d256", n0, 256);
        check("busy_len_d200", n1, 200);

        // Every word reads back zero after the power-on clear.
        for (int i = 0; i < 256; i++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(i);
            tick();
            check("t1_valid0", rd_valid0, 1);
            check("t1_data0", rd_data0, 0);
            if (i < D1)  check("t1_data1", rd_data1, 0);
            if (i == 199) check("t1_err1_in_range", err1, 0);
            if (i == 200) check("t1_err1_oob", err1, 1);
        end
        idle();
        tick();
        check("t1_valid_drop", rd_valid0, 0);
        check("t1_err0", err0, 0);

        wr_en = 1'b1; wr_addr = 8'd210; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd210;
        tick();
        check("t6_rd_data1", rd_data1, 0);
        check("t6_valid1", rd_valid1, 1);
        check("t6_err1", err1, 1);
        check("t6_rd_data0", rd_data0, 8'hFF);
        idle();

        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(5 * i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rd_en = 1'b1; rd_addr = 8'(i);
            tick();
            check("t2_data0", rd_data0, (5 * i) % 256);
            check("t2_valid0", rd_valid0, 1);
        end
        idle();
        tick();
        check("t2_err0", err0, 0);

        wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5;
        rd_en = 1'b1; rd_addr = 8'h10;
        tick();
        check("t3_fwd0", rd_data0, 8'hA5);
        check("t3_fwd1", rd_data1, 8'hA5);
        idle();

        // Clear pulse, a write while busy and a second pulse mid-clear.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_busy_after_pulse", busy0, 1);
        nb = 0;
        wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h3C;
        for (int c = 0; c < 1000 && busy0; c++) begin
            tick();
            nb++;
            wr_en = 1'b0;
            clr   = (nb == 50);
            if (nb == 1) check("t4_err_busy", err0, 1);
        end
        idle();
        check("t5_busy_len", nb, 256);
        rd_en = 1'b1; rd_addr = 8'h20;
        tick();
        check("t4_read_cleared", rd_data0, 8'h00);
        rd_addr = 8'h10;
        tick();
        check("t5_read_cleared", rd_data0, 8'h00);
        idle();

        for (int c = 0; c < 3000; c++) begin
            clr   = ($urandom_range(0, 99) == 0);
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            rd_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            wr_data = 8'($urandom);
            tick();
        end
        idle();

        // Reset in the middle of a clear restarts it from address 0.
        wait_clear(n0, n1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_err0", err0, 0);
        check("t6_rst_err1", err1, 0);
        check("t6_rst_rd_data1", rd_data1, 0);
        check("t6_rst_busy1", busy1, 1);
        wait_clear(n0, n1);
        check("t6_busy_len_d200", n1, 200);
        check("t6_busy_len_d256", n0, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
